eth32bit_sched: RTL and testbench
=================================

Name: eth32bit_sched

Overview:
Ingress-buffered switch scheduler for the 2-port 32-bit Ethernet switch.
- Each ingress port (A, B) feeds a DEPTH-word FIFO.
- Each egress port (A, B) has a round-robin arbiter that chooses between the two FIFO heads addressed to it.
- Egress uses a valid/ack handshake with backpressure.
- Words whose dest field is not a valid port are dropped and counted.

Parameters:
DEPTH, 4, ingress FIFO depth per port in words; power of 2, >=2
ADDR_A, 2'b01, dest field value routing a word to egress A
ADDR_B, 2'b10, dest field value routing a word to egress B
CNT_W, 16, width of the drop counter

Ports:
clk  in  1  single clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
inDataA  in  32  ingress A word; dest field = bits [31:30]
Ain  in  1  ingress A valid
inRdyA  out  1  ingress A ready (FIFO A not full)
inDataB  in  32  ingress B word
Bin  in  1  ingress B valid
inRdyB  out  1  ingress B ready
outDataA  out  32  egress A word
Aout  out  1  egress A valid
outAckA  in  1  egress A sink ready
outDataB  out  32  egress B word
Bout  out  1  egress B valid
outAckB  in  1  egress B sink ready
drop_cnt  out  CNT_W  count of dropped ingress words, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both FIFOs empty; outDataA/B = 0; Aout/Bout = 0; drop_cnt = 0.
  - Both egress round-robin pointers favour ingress A.
  - inRdyA/B = 1 (FIFO empty).
  - Ingress inputs are ignored while rst_n is low.
  - Reset mid-operation discards all buffered and held words; no stale word reappears after release.
- Ingress acceptance:
  - A word is accepted at a posedge when Ain && inRdyA (likewise B).
  - inRdyX = !fullX, derived from the FIFO occupancy count only; no bypass when full.
- Ingress routing:
  - dest == ADDR_A or ADDR_B: the word is written to its ingress FIFO.
  - Any other dest (2'b00, 2'b11): the word is accepted but not written; drop_cnt += 1.
  - Both ports drop in the same cycle: drop_cnt += 2.
  - drop_cnt saturates at all-ones.
- FIFO:
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - Strict FIFO order per ingress. Head-of-line blocking is intended: a blocked head stalls all later words from that ingress.
- Egress holding register (one per egress port):
  - Aout = 1 means outDataA holds a word. The word completes on a posedge with Aout && outAckA.
  - While Aout && !outAckA, outDataA is stable and Aout stays 1.
  - The register may load a new word in the same cycle it completes one, giving full throughput of 1 word/cycle/port.
- Eligibility and arbitration (per egress port E, evaluated each cycle):
  - A FIFO head is eligible for E if that FIFO is non-empty, its head dest matches E, and E's register is empty or completing this cycle.
  - One eligible head: it is granted.
  - Two eligible heads: the pointer's favoured ingress is granted, and the pointer moves to the other ingress.
  - A grant with no contention also moves the pointer to the non-granted ingress.
  - A granted head is popped and loaded into E's register at the same posedge.
  - A and B egress decisions are independent. Each head has exactly one dest, so it is never double-granted.
- Latency: a word accepted at posedge k into an empty path has Aout/Bout = 1 after posedge k+1 (FIFO write at k, load at k+1).
- Simultaneous events:
  - Cross traffic (A→B and B→A in the same cycle) is delivered on both egresses in the same cycle.
  - Push to a full FIFO is impossible (inRdy = 0).
  - A pop in the same cycle as a full FIFO does not raise inRdy until the next cycle.

Test Plan:
1. Reset release; Ain=1, inDataA=0x4000_0001 for one cycle at posedge k; outAckA=1 -> Aout=1, outDataA=0x4000_0001 after posedge k+1 for one cycle; Bout stays 0; drop_cnt=0.
2. Same posedge: A sends 0x8000_00AA, B sends 0x4000_00BB; both acks=1 -> after the next posedge, outDataB=0x8000_00AA with Bout=1 and outDataA=0x4000_00BB with Aout=1, in the same cycle.
3. Contention: A sends 0x8000_0A00..03 and B sends 0x8000_0B00..03 back-to-back; outAckB=1 -> egress B order is 0A00,0B00,0A01,0B01,0A02,0B02,0A03,0B03 on consecutive cycles.
4. Backpressure, DEPTH=4: outAckA=0; A sends 6 words 0x4000_0000..05 (dest A) -> word 0 held; words 1-4 fill the FIFO; inRdyA=0; word 5 held at input. Raise outAckA -> all 6 emerge in order, one per cycle, none lost.
5. Drops: A sends 0x0000_0001 and B sends 0xC000_0000 in the same cycle -> drop_cnt=2, no Aout/Bout. Preload drop_cnt at all-ones via repeated drops -> it stays at all-ones.
6. Reset mid-operation: fill FIFO A with 3 words while outAckA=0; pulse rst_n low between edges -> Aout=0 and inRdyA=1 immediately. After release with outAckA=1, no output appears until new input arrives.

Source files
------------

// File: rtl/eth32bit_sched_if.sv
// eth32bit_sched_if: ingress/egress bus bundle for the 2-port switch scheduler
interface eth32bit_sched_if #(parameter int CNT_W = 16);
  logic [31:0] inDataA, inDataB, outDataA, outDataB;
  logic Ain, Bin, inRdyA, inRdyB, Aout, Bout, outAckA, outAckB;
  logic [CNT_W-1:0] drop_cnt;
  modport master(output inDataA, Ain, inDataB, Bin, outAckA, outAckB,
                 input inRdyA, inRdyB, outDataA, Aout, outDataB, Bout, drop_cnt);
  modport slave(input inDataA, Ain, inDataB, Bin, outAckA, outAckB,
                output inRdyA, inRdyB, outDataA, Aout, outDataB, Bout, drop_cnt);
endinterface

// File: rtl/eth32bit_sched.sv
// eth32bit_sched: ingress FIFOs per port, round-robin arbitration per egress, valid/ack egress
module eth32bit_sched #(
  parameter int DEPTH = 4,
  parameter logic [1:0] ADDR_A = 2'b01,
  parameter logic [1:0] ADDR_B = 2'b10,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  eth32bit_sched_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [31:0] in_data [2];
  logic [1:0] in_vld, out_ack;
  logic [31:0] mem_q [2][DEPTH], mem_d [2][DEPTH];
  logic [PW-1:0] wp_q [2], wp_d [2], rp_q [2], rp_d [2];
  logic [CW-1:0] cnt_q [2], cnt_d [2];
  logic [31:0] out_q [2], out_d [2];
  logic [1:0] ovld_q, ovld_d, rr_q, rr_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W:0] drop_sum;
  logic [1:0] rdy, push, drop, pop, elig, dst_ok;
  logic [1:0] addr;
  logic g;
  assign in_data = '{bus.inDataA, bus.inDataB};
  assign in_vld = {bus.Bin, bus.Ain};
  assign out_ack = {bus.outAckB, bus.outAckA};
  assign bus.inRdyA = rdy[0];
  assign bus.inRdyB = rdy[1];
  assign bus.outDataA = out_q[0];
  assign bus.outDataB = out_q[1];
  assign bus.Aout = ovld_q[0];
  assign bus.Bout = ovld_q[1];
  assign bus.drop_cnt = drop_q;
  always_comb begin
    mem_d = mem_q;
    wp_d = wp_q;
    rp_d = rp_q;
    cnt_d = cnt_q;
    out_d = out_q;
    ovld_d = ovld_q;
    rr_d = rr_q;
    pop = '0;
    elig = '0;
    addr = ADDR_A;
    g = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = cnt_q[i] != CW'(DEPTH);
      dst_ok[i] = in_data[i][31:30] == ADDR_A || in_data[i][31:30] == ADDR_B;
      push[i] = in_vld[i] && rdy[i] && dst_ok[i];
      drop[i] = in_vld[i] && rdy[i] && !dst_ok[i];
    end
    // rr_q[e] holds the ingress favoured on contention; it flips away from every grant
    for (int e = 0; e < 2; e++) begin
      addr = e == 0 ? ADDR_A : ADDR_B;
      for (int i = 0; i < 2; i++)
        elig[i] = cnt_q[i] != '0 && mem_q[i][rp_q[i]][31:30] == addr && (!ovld_q[e] || out_ack[e]);
      g = elig == 2'b11 ? rr_q[e] : elig[1];
      if (|elig) begin
        out_d[e] = mem_q[g][rp_q[g]];
        ovld_d[e] = 1'b1;
        rr_d[e] = !g;
        pop[g] = 1'b1;
      end else if (out_ack[e]) begin
        ovld_d[e] = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_d[i][wp_q[i]] = in_data[i];
        wp_d[i] = wp_q[i] + PW'(1);
      end
      if (pop[i]) rp_d[i] = rp_q[i] + PW'(1);
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
    drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop[0]) + (CNT_W+1)'(drop[1]);
    drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int d = 0; d < DEPTH; d++) mem_q[i][d] <= '0;
        wp_q[i] <= '0;
        rp_q[i] <= '0;
        cnt_q[i] <= '0;
        out_q[i] <= '0;
      end
      ovld_q <= '0;
      rr_q <= '0;
      drop_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      ovld_q <= ovld_d;
      rr_q <= rr_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_eth32bit_sched.sv
// tb_eth32bit_sched: directed checks of routing, arbitration, backpressure, drops and reset
module tb_eth32bit_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_b [8];
  eth32bit_sched_if bus();
  eth32bit_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic pulse_rst();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask
  initial begin
    bus.Ain = 0; bus.Bin = 0; bus.inDataA = 0; bus.inDataB = 0;
    bus.outAckA = 1; bus.outAckB = 1;
    tick();
    tick();
    chk("rst_aout", 32'(bus.Aout), 0);
    chk("rst_bout", 32'(bus.Bout), 0);
    chk("rst_outa", bus.outDataA, 0);
    chk("rst_outb", bus.outDataB, 0);
    chk("rst_rdya", 32'(bus.inRdyA), 1);
    chk("rst_rdyb", 32'(bus.inRdyB), 1);
    chk("rst_drop", 32'(bus.drop_cnt), 0);
    rst_n = 1'b1;
    // single word A->A, latency two posedges
    bus.Ain = 1; bus.inDataA = 32'h4000_0001;
    tick();
    bus.Ain = 0;
    chk("t1_early", 32'(bus.Aout), 0);
    tick();
    chk("t1_aout", 32'(bus.Aout), 1);
    chk("t1_data", bus.outDataA, 32'h4000_0001);
    chk("t1_bout", 32'(bus.Bout), 0);
    tick();
    chk("t1_done", 32'(bus.Aout), 0);
    chk("t1_drop", 32'(bus.drop_cnt), 0);
    // cross traffic
    bus.Ain = 1; bus.inDataA = 32'h8000_00AA;
    bus.Bin = 1; bus.inDataB = 32'h4000_00BB;
    tick();
    bus.Ain = 0; bus.Bin = 0;
    tick();
    chk("t2_bout", 32'(bus.Bout), 1);
    chk("t2_outb", bus.outDataB, 32'h8000_00AA);
    chk("t2_aout", 32'(bus.Aout), 1);
    chk("t2_outa", bus.outDataA, 32'h4000_00BB);
    tick();
    chk("t2_idle", {30'd0, bus.Aout, bus.Bout}, 0);
    // contention on egress B, pointers restored to favour A
    pulse_rst();
    for (int i = 0; i < 4; i++) begin
      exp_b[2*i] = 32'h8000_0A00 + 32'(i);
      exp_b[2*i+1] = 32'h8000_0B00 + 32'(i);
    end
    for (int c = 0; c < 9; c++) begin
      bus.Ain = c < 4; bus.inDataA = 32'h8000_0A00 + 32'(c);
      bus.Bin = c < 4; bus.inDataB = 32'h8000_0B00 + 32'(c);
      tick();
      if (c >= 1) begin
        chk($sformatf("t3_bout%0d", c), 32'(bus.Bout), 1);
        chk($sformatf("t3_outb%0d", c), bus.outDataB, exp_b[c-1]);
        chk($sformatf("t3_aout%0d", c), 32'(bus.Aout), 0);
      end
    end
    tick();
    chk("t3_idle", 32'(bus.Bout), 0);
    // backpressure on egress A
    bus.outAckA = 0;
    for (int w = 0; w < 5; w++) begin
      bus.Ain = 1; bus.inDataA = 32'h4000_0000 + 32'(w);
      tick();
    end
    bus.inDataA = 32'h4000_0005;
    for (int c = 0; c < 3; c++) begin
      chk("t4_rdy_low", 32'(bus.inRdyA), 0);
      chk("t4_hold_v", 32'(bus.Aout), 1);
      chk("t4_hold_d", bus.outDataA, 32'h4000_0000);
      tick();
    end
    bus.outAckA = 1;
    tick();
    chk("t4_w1", bus.outDataA, 32'h4000_0001);
    chk("t4_rdy_up", 32'(bus.inRdyA), 1);
    tick();
    bus.Ain = 0;
    chk("t4_w2", bus.outDataA, 32'h4000_0002);
    for (int w = 3; w < 6; w++) begin
      tick();
      chk($sformatf("t4_v%0d", w), 32'(bus.Aout), 1);
      chk($sformatf("t4_w%0d", w), bus.outDataA, 32'h4000_0000 + 32'(w));
    end
    tick();
    chk("t4_idle", 32'(bus.Aout), 0);
    // drops and saturation
    bus.Ain = 1; bus.inDataA = 32'h0000_0001;
    bus.Bin = 1; bus.inDataB = 32'hC000_0000;
    tick();
    bus.Ain = 0; bus.Bin = 0;
    chk("t5_drop2", 32'(bus.drop_cnt), 2);
    tick();
    chk("t5_no_out", {30'd0, bus.Aout, bus.Bout}, 0);
    bus.Ain = 1; bus.Bin = 1;
    for (int c = 0; c < 32766; c++) tick();
    chk("t5_fffe", 32'(bus.drop_cnt), 32'hFFFE);
    tick();
    chk("t5_sat", 32'(bus.drop_cnt), 32'hFFFF);
    tick();
    chk("t5_stay", 32'(bus.drop_cnt), 32'hFFFF);
    bus.Ain = 0; bus.Bin = 0;
    // reset mid-operation
    bus.outAckA = 0;
    for (int w = 0; w < 3; w++) begin
      bus.Ain = 1; bus.inDataA = 32'h4000_0010 + 32'(w);
      tick();
    end
    bus.Ain = 0;
    tick();
    chk("t6_pre", 32'(bus.Aout), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_aout", 32'(bus.Aout), 0);
    chk("t6_rdya", 32'(bus.inRdyA), 1);
    chk("t6_drop", 32'(bus.drop_cnt), 0);
    rst_n = 1'b1;
    bus.outAckA = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t6_quiet%0d", c), 32'(bus.Aout), 0);
    end
    bus.Ain = 1; bus.inDataA = 32'h4000_0077;
    tick();
    bus.Ain = 0;
    tick();
    chk("t6_new_v", 32'(bus.Aout), 1);
    chk("t6_new_d", bus.outDataA, 32'h4000_0077);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
